legv8_control_fsm: RTL and testbench

Multi-cycle control unit that drives the ALU function select and datapath enables, and consumes the ALU's {V,C,Z,N} status. It decodes a LEGv8 subset and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It holds the architectural flags register and resolves CBZ/CBNZ/B.cond/B. It sits between instruction memory and the datapath (register file, ALU, data memory, PC).

---
 rtl/legv8_ctrl_pkg.sv | 189 ++++++++++++++++++
 rtl/cond_eval.sv | 48 ++++
 rtl/legv8_control_fsm.sv | 184 ++++++++++++++++++
 tb/tb_legv8_control_fsm.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// Shared constants, types and the instruction decoder for the LEGv8 multi-cycle control unit.
package legv8_ctrl_pkg;

    // Control sequencer states; the numeric values are visible on the state output.
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;

    // Instruction classes that select the sequence of states after DECODE.
    typedef enum logic [2:0] {
        CL_ALU,
        CL_LDUR,
        CL_STUR,
        CL_CBZ,
        CL_CBNZ,
        CL_BCOND,
        CL_B,
        CL_ILLEGAL
    } iclass_t;

    // ALU function select: [4:2] op, [1] A invert, [0] B invert / carry-in.
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    // ALU B-operand source.
    localparam logic [1:0] BSEL_REG  = 2'b00;
    localparam logic [1:0] BSEL_IMM  = 2'b01;
    localparam logic [1:0] BSEL_ZERO = 2'b10;

    // Bit positions inside a {V,C,Z,N} nibble.
    localparam int ST_N = 0;
    localparam int ST_Z = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

    // R-type and D-type opcodes, IR[31:21].
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_ANDS = 11'b11101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    // I-type opcodes, IR[31:22].
    localparam logic [9:0] OP_ADDI = 10'b1001000100;
    localparam logic [9:0] OP_SUBI = 10'b1101000100;
    localparam logic [9:0] OP_ANDI = 10'b1001001000;
    localparam logic [9:0] OP_ORRI = 10'b1011001000;
    localparam logic [9:0] OP_EORI = 10'b1101001000;

    // CB-type opcodes, IR[31:24], and unconditional branch, IR[31:26].
    localparam logic [7:0] OP_CBZ   = 8'b10110100;
    localparam logic [7:0] OP_CBNZ  = 8'b10110101;
    localparam logic [7:0] OP_BCOND = 8'b01010100;
    localparam logic [5:0] OP_B     = 6'b000101;

    // B.cond condition codes, IR[3:0].
    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // Everything the sequencer needs to know about one instruction word.
    typedef struct packed {
        iclass_t     cls;
        logic        set_flags;
        logic [4:0]  fs;
        logic [1:0]  b_sel;
        logic [63:0] imm;
        logic [63:0] branch_offset;
    } decode_t;

    // Widest opcode field is tried first; the encodings are disjoint across widths.
    function automatic decode_t decode_instr(input logic [31:0] ir);
        decode_t d;
        d.cls           = CL_ILLEGAL;
        d.set_flags     = 1'b0;
        d.fs            = FS_AND;
        d.b_sel         = BSEL_REG;
        d.imm           = '0;
        d.branch_offset = '0;

        case (ir[31:21])
            OP_ADD, OP_ADDS: begin
                d.cls       = CL_ALU;
                d.fs        = FS_ADD;
                d.set_flags = (ir[31:21] == OP_ADDS);
            end
            OP_SUB, OP_SUBS: begin
                d.cls       = CL_ALU;
                d.fs        = FS_SUB;
                d.set_flags = (ir[31:21] == OP_SUBS);
            end
            OP_AND, OP_ANDS: begin
                d.cls       = CL_ALU;
                d.fs        = FS_AND;
                d.set_flags = (ir[31:21] == OP_ANDS);
            end
            OP_ORR: begin
                d.cls = CL_ALU;
                d.fs  = FS_OR;
            end
            OP_EOR: begin
                d.cls = CL_ALU;
                d.fs  = FS_XOR;
            end
            OP_LSL, OP_LSR: begin
                d.cls   = CL_ALU;
                d.fs    = (ir[31:21] == OP_LSL) ? FS_LSL : FS_LSR;
                d.b_sel = BSEL_IMM;
                d.imm   = {58'd0, ir[15:10]};
            end
            OP_LDUR, OP_STUR: begin
                d.cls   = (ir[31:21] == OP_LDUR) ? CL_LDUR : CL_STUR;
                d.fs    = FS_ADD;
                d.b_sel = BSEL_IMM;
                d.imm   = {{55{ir[20]}}, ir[20:12]};
            end
            default: ;
        endcase

        if (d.cls == CL_ILLEGAL) begin
            d.b_sel = BSEL_IMM;
            d.imm   = {52'd0, ir[21:10]};
            case (ir[31:22])
                OP_ADDI: begin d.cls = CL_ALU; d.fs = FS_ADD; end
                OP_SUBI: begin d.cls = CL_ALU; d.fs = FS_SUB; end
                OP_ANDI: begin d.cls = CL_ALU; d.fs = FS_AND; end
                OP_ORRI: begin d.cls = CL_ALU; d.fs = FS_OR;  end
                OP_EORI: begin d.cls = CL_ALU; d.fs = FS_XOR; end
                default: begin d.b_sel = BSEL_REG; d.imm = '0; end
            endcase
        end

        if (d.cls == CL_ILLEGAL) begin
            d.branch_offset = {{43{ir[23]}}, ir[23:5], 2'b00};
            case (ir[31:24])
                OP_CBZ: begin
                    d.cls   = CL_CBZ;
                    d.fs    = FS_OR;
                    d.b_sel = BSEL_ZERO;
                end
                OP_CBNZ: begin
                    d.cls   = CL_CBNZ;
                    d.fs    = FS_OR;
                    d.b_sel = BSEL_ZERO;
                end
                OP_BCOND: d.cls = CL_BCOND;
                default:  d.branch_offset = '0;
            endcase
        end

        if (d.cls == CL_ILLEGAL && ir[31:26] == OP_B) begin
            d.cls           = CL_B;
            d.branch_offset = {{36{ir[25]}}, ir[25:0], 2'b00};
        end

        return d;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational B.cond evaluator: decides "taken" from the latched {V,C,Z,N} flags.
module cond_eval
    import legv8_ctrl_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [3:0] i_cond,
    output logic       o_taken
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_hi;
    logic w_gt;

    assign w_n  = i_flags[ST_N];
    assign w_z  = i_flags[ST_Z];
    assign w_c  = i_flags[ST_C];
    assign w_v  = i_flags[ST_V];
    assign w_hi = w_c & ~w_z;
    assign w_gt = ~w_z & (w_n == w_v);

    // Select the flag predicate named by the condition code.
    always_comb begin
        // NOTE: every variable driven here gets a value before the case, so no latch can be inferred.
        o_taken = 1'b1;
        case (i_cond)
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = ~w_z;
            COND_HS: o_taken = w_c;
            COND_LO: o_taken = ~w_c;
            COND_MI: o_taken = w_n;
            COND_PL: o_taken = ~w_n;
            COND_VS: o_taken = w_v;
            COND_VC: o_taken = ~w_v;
            COND_HI: o_taken = w_hi;
            COND_LS: o_taken = ~w_hi;
            COND_GE: o_taken = (w_n == w_v);
            COND_LT: o_taken = (w_n != w_v);
            COND_GT: o_taken = w_gt;
            COND_LE: o_taken = ~w_gt;
            COND_AL, COND_NV: o_taken = 1'b1;
            default: o_taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: IR, flags register, decode and the F/D/E/M/WB sequencer.
module legv8_control_fsm
    import legv8_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic [3:0]  status,
    output logic [4:0]  fs,
    output logic [1:0]  b_sel,
    output logic [63:0] imm,
    output logic [63:0] branch_offset,
    output logic [4:0]  rn_addr,
    output logic [4:0]  rm_addr,
    output logic [4:0]  rd_addr,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [3:0]  flags,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t      r_state;
    logic [31:0] r_ir;
    logic [3:0]  r_flags;
    logic        r_illegal;
    logic [4:0]  r_fs;
    logic [1:0]  r_b_sel;
    logic [63:0] r_imm;
    logic [63:0] r_branch_offset;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_mem_to_reg;
    logic        r_pc_we;

    decode_t     w_dec;
    logic        w_is_branch;
    logic        w_cond_taken;
    logic        w_taken;

    // The IR is stable from DECODE onward, so decode straight from it.
    assign w_dec       = decode_instr(r_ir);
    assign w_is_branch = (w_dec.cls == CL_CBZ) || (w_dec.cls == CL_CBNZ) ||
                         (w_dec.cls == CL_BCOND) || (w_dec.cls == CL_B);

    cond_eval u_cond_eval (
        .i_flags (r_flags),
        .i_cond  (r_ir[3:0]),
        .o_taken (w_cond_taken)
    );

    // CBZ/CBNZ look at the live ALU zero (Rt OR 0); B.cond uses only the latched flags.
    always_comb begin
        w_taken = 1'b0;
        case (w_dec.cls)
            CL_CBZ:   w_taken = status[ST_Z];
            CL_CBNZ:  w_taken = ~status[ST_Z];
            CL_BCOND: w_taken = w_cond_taken;
            CL_B:     w_taken = 1'b1;
            default:  w_taken = 1'b0;
        endcase
    end

    // Rt replaces Rm as the second read port for stores and compare-and-branch.
    always_comb begin
        rm_addr = r_ir[20:16];
        case (w_dec.cls)
            CL_STUR, CL_CBZ, CL_CBNZ: rm_addr = r_ir[4:0];
            default:                  rm_addr = r_ir[20:16];
        endcase
    end

    // Sequencer with registered enables: each enable is set on entry to the state that owns it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= FETCH;
            r_ir            <= '0;
            r_flags         <= '0;
            r_illegal       <= 1'b0;
            r_fs            <= '0;
            r_b_sel         <= '0;
            r_imm           <= '0;
            r_branch_offset <= '0;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_pc_we         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch below sees the pre-edge register values.
            case (r_state)
                FETCH: begin
                    r_ir    <= instr;
                    r_state <= DECODE;
                end
                DECODE: begin
                    if (w_dec.cls == CL_ILLEGAL) begin
                        r_state   <= TRAP;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state         <= EXECUTE;
                        r_fs            <= w_dec.fs;
                        r_b_sel         <= w_dec.b_sel;
                        r_imm           <= w_dec.imm;
                        r_branch_offset <= w_dec.branch_offset;
                        r_pc_we         <= w_is_branch;
                    end
                end
                EXECUTE: begin
                    if (w_dec.set_flags) begin
                        r_flags <= status;
                    end
                    case (w_dec.cls)
                        CL_LDUR: begin
                            r_state    <= MEM;
                            r_mem_read <= 1'b1;
                        end
                        CL_STUR: begin
                            r_state     <= MEM;
                            r_mem_write <= 1'b1;
                            r_pc_we     <= 1'b1;
                        end
                        CL_ALU: begin
                            r_state     <= WRITEBACK;
                            r_reg_write <= 1'b1;
                            r_pc_we     <= 1'b1;
                        end
                        default: begin
                            r_state <= FETCH;
                            r_pc_we <= 1'b0;
                        end
                    endcase
                end
                MEM: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    if (w_dec.cls == CL_LDUR) begin
                        r_state      <= WRITEBACK;
                        r_reg_write  <= 1'b1;
                        r_mem_to_reg <= 1'b1;
                        r_pc_we      <= 1'b1;
                    end else begin
                        r_state <= FETCH;
                        r_pc_we <= 1'b0;
                    end
                end
                WRITEBACK: begin
                    r_state      <= FETCH;
                    r_reg_write  <= 1'b0;
                    r_mem_to_reg <= 1'b0;
                    r_pc_we      <= 1'b0;
                end
                TRAP: begin
                    r_state <= TRAP;
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign state         = r_state;
    assign fs            = r_fs;
    assign b_sel         = r_b_sel;
    assign imm           = r_imm;
    assign branch_offset = r_branch_offset;
    assign rn_addr       = r_ir[9:5];
    assign rd_addr       = r_ir[4:0];
    assign reg_write     = r_reg_write;
    assign mem_read      = r_mem_read;
    assign mem_write     = r_mem_write;
    assign mem_to_reg    = r_mem_to_reg;
    assign pc_we         = r_pc_we;
    assign pc_sel        = r_pc_we & (r_state == EXECUTE) & w_taken;
    assign flags         = r_flags;
    assign illegal       = r_illegal;

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Directed bench for legv8_control_fsm with a table-driven instruction model and per-cycle compare.
module tb_legv8_control_fsm;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic [3:0]  status;
    logic [4:0]  fs;
    logic [1:0]  b_sel;
    logic [63:0] imm;
    logic [63:0] branch_offset;
    logic [4:0]  rn_addr;
    logic [4:0]  rm_addr;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        pc_we;
    logic        pc_sel;
    logic [3:0]  flags;
    logic        illegal;
    logic [2:0]  state;

    legv8_control_fsm dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .instr         (instr),
        .status        (status),
        .fs            (fs),
        .b_sel         (b_sel),
        .imm           (imm),
        .branch_offset (branch_offset),
        .rn_addr       (rn_addr),
        .rm_addr       (rm_addr),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .flags         (flags),
        .illegal       (illegal),
        .state         (state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- instruction model ----------------
    typedef enum int {K_ALU, K_LD, K_ST, K_CBZ, K_CBNZ, K_BC, K_B} kind_t;

    typedef struct {
        int          width;
        logic [10:0] opc;
        kind_t       kind;
        logic [4:0]  fs;
        logic [1:0]  bsel;
        int          immk;   // 0 none, 1 shamt IR[15:10], 2 uimm IR[21:10], 3 simm IR[20:12]
        bit          rtype;
        bit          sets;
    } op_t;

    op_t optab[$];

    function automatic void add_op(int w, logic [10:0] opc, kind_t k, logic [4:0] f,
                                   logic [1:0] bs, int ik, bit rt, bit s);
        op_t e;
        e.width = w; e.opc = opc; e.kind = k; e.fs = f; e.bsel = bs;
        e.immk = ik; e.rtype = rt; e.sets = s;
        optab.push_back(e);
    endfunction

    function automatic int find_op(logic [31:0] ir);
        for (int i = 0; i < optab.size(); i++) begin
            logic [31:0] sh;
            sh = ir >> (32 - optab[i].width);
            if (sh == 32'(optab[i].opc)) return i;
        end
        return -1;
    endfunction

    function automatic logic [63:0] m_imm(int k, logic [31:0] ir);
        longint v;
        case (k)
            1: v = longint'(ir[15:10]);
            2: v = longint'(ir[21:10]);
            3: begin
                v = longint'(ir[20:12]);
                if (v >= 256) v = v - 512;
            end
            default: v = 0;
        endcase
        return 64'(v);
    endfunction

    function automatic logic [63:0] m_boff(kind_t k, logic [31:0] ir);
        longint v;
        if (k == K_B) begin
            v = longint'(ir[25:0]);
            if (v >= (longint'(1) << 25)) v = v - (longint'(1) << 26);
        end else begin
            v = longint'(ir[23:5]);
            if (v >= (longint'(1) << 18)) v = v - (longint'(1) << 19);
        end
        return 64'(v * 4);
    endfunction

    function automatic bit m_cond(logic [3:0] f, logic [3:0] c);
        bit v, cc, z, n;
        v = f[3]; cc = f[2]; z = f[1]; n = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cc;
            4'd3:  return !cc;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cc && !z;
            4'd9:  return !(cc && !z);
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    logic [3:0]  m_flags;
    logic [4:0]  cap_fs;
    logic [63:0] cap_imm;
    logic [63:0] cap_boff;
    logic        cap_pc_sel;
    logic [3:0]  cap_flags;

    // Runs one instruction from FETCH to the next FETCH, comparing every cycle.
    task automatic run_instr(input string tag, input logic [31:0] ir, input logic [3:0] st);
        int    idx;
        op_t   e;
        int    lat;
        int    es;
        bit    br;
        bit    taken;
        bit    last;
        instr  = ir;
        status = st;
        idx = find_op(ir);
        if (idx < 0) begin
            n_errors++;
            $display("FAIL %s: bench has no model entry for 0x%08h", tag, ir);
            return;
        end
        e  = optab[idx];
        br = (e.kind == K_CBZ) || (e.kind == K_CBNZ) || (e.kind == K_BC) || (e.kind == K_B);
        case (e.kind)
            K_ALU:   lat = 4;
            K_LD:    lat = 5;
            K_ST:    lat = 4;
            default: lat = 3;
        endcase
        case (e.kind)
            K_CBZ:   taken = st[1];
            K_CBNZ:  taken = !st[1];
            K_BC:    taken = m_cond(m_flags, ir[3:0]);
            K_B:     taken = 1'b1;
            default: taken = 1'b0;
        endcase
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clock);
            last = (k == lat);
            case (k)
                1:       es = 0;
                2:       es = 1;
                3:       es = 2;
                4:       es = (e.kind == K_ALU) ? 4 : 3;
                default: es = 4;
            endcase
            check($sformatf("%s c%0d state", tag, k), 64'(state), 64'(es));
            check($sformatf("%s c%0d pc_we", tag, k), 64'(pc_we), 64'(last));
            check($sformatf("%s c%0d pc_sel", tag, k), 64'(pc_sel), 64'(last && br && taken));
            check($sformatf("%s c%0d reg_write", tag, k), 64'(reg_write),
                  64'(last && (e.kind == K_ALU || e.kind == K_LD)));
            check($sformatf("%s c%0d mem_to_reg", tag, k), 64'(mem_to_reg), 64'(last && e.kind == K_LD));
            check($sformatf("%s c%0d mem_read", tag, k), 64'(mem_read), 64'(k == 4 && e.kind == K_LD));
            check($sformatf("%s c%0d mem_write", tag, k), 64'(mem_write), 64'(k == 4 && e.kind == K_ST));
            check($sformatf("%s c%0d flags", tag, k), 64'(flags), 64'(m_flags));
            check($sformatf("%s c%0d illegal", tag, k), 64'(illegal), 64'd0);
            if (k >= 2) begin
                check($sformatf("%s c%0d rn", tag, k), 64'(rn_addr), 64'(ir[9:5]));
                check($sformatf("%s c%0d rd", tag, k), 64'(rd_addr), 64'(ir[4:0]));
                if (e.rtype)
                    check($sformatf("%s c%0d rm", tag, k), 64'(rm_addr), 64'(ir[20:16]));
                if (e.kind == K_ST || e.kind == K_CBZ || e.kind == K_CBNZ)
                    check($sformatf("%s c%0d rt", tag, k), 64'(rm_addr), 64'(ir[4:0]));
            end
            if (k >= 3 && e.kind != K_BC && e.kind != K_B) begin
                check($sformatf("%s c%0d fs", tag, k), 64'(fs), 64'(e.fs));
                check($sformatf("%s c%0d b_sel", tag, k), 64'(b_sel), 64'(e.bsel));
                if (e.immk != 0)
                    check($sformatf("%s c%0d imm", tag, k), imm, m_imm(e.immk, ir));
            end
            if (k == 3 && br)
                check($sformatf("%s c%0d branch_offset", tag, k), branch_offset, m_boff(e.kind, ir));
            if (k == 3) begin
                cap_fs   = fs;
                cap_imm  = imm;
                cap_boff = branch_offset;
            end
            if (last) cap_pc_sel = pc_sel;
            if (k == 3 && e.sets) m_flags = st;
        end
        @(negedge clock);
        cap_flags = flags;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state"}, 64'(state), 64'd0);
        check({tag, " flags"}, 64'(flags), 64'd0);
        check({tag, " illegal"}, 64'(illegal), 64'd0);
        check({tag, " enables"}, 64'({reg_write, mem_read, mem_write, mem_to_reg, pc_we, pc_sel}), 64'd0);
        check({tag, " fs"}, 64'(fs), 64'd0);
        check({tag, " b_sel"}, 64'(b_sel), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        add_op(11, 11'b10001011000, K_ALU, 5'b01000, 2'b00, 0, 1, 0); // ADD
        add_op(11, 11'b11001011000, K_ALU, 5'b01001, 2'b00, 0, 1, 0); // SUB
        add_op(11, 11'b10001010000, K_ALU, 5'b00000, 2'b00, 0, 1, 0); // AND
        add_op(11, 11'b10101010000, K_ALU, 5'b00100, 2'b00, 0, 1, 0); // ORR
        add_op(11, 11'b11001010000, K_ALU, 5'b01100, 2'b00, 0, 1, 0); // EOR
        add_op(11, 11'b10101011000, K_ALU, 5'b01000, 2'b00, 0, 1, 1); // ADDS
        add_op(11, 11'b11101011000, K_ALU, 5'b01001, 2'b00, 0, 1, 1); // SUBS
        add_op(11, 11'b11101010000, K_ALU, 5'b00000, 2'b00, 0, 1, 1); // ANDS
        add_op(11, 11'b11010011011, K_ALU, 5'b10000, 2'b01, 1, 1, 0); // LSL
        add_op(11, 11'b11010011010, K_ALU, 5'b10100, 2'b01, 1, 1, 0); // LSR
        add_op(10, 11'b1001000100,  K_ALU, 5'b01000, 2'b01, 2, 0, 0); // ADDI
        add_op(10, 11'b1101000100,  K_ALU, 5'b01001, 2'b01, 2, 0, 0); // SUBI
        add_op(10, 11'b1001001000,  K_ALU, 5'b00000, 2'b01, 2, 0, 0); // ANDI
        add_op(10, 11'b1011001000,  K_ALU, 5'b00100, 2'b01, 2, 0, 0); // ORRI
        add_op(10, 11'b1101001000,  K_ALU, 5'b01100, 2'b01, 2, 0, 0); // EORI
        add_op(11, 11'b11111000010, K_LD,  5'b01000, 2'b01, 3, 0, 0); // LDUR
        add_op(11, 11'b11111000000, K_ST,  5'b01000, 2'b01, 3, 0, 0); // STUR
        add_op(8,  11'b10110100,    K_CBZ, 5'b00100, 2'b10, 0, 0, 0); // CBZ
        add_op(8,  11'b10110101,    K_CBNZ,5'b00100, 2'b10, 0, 0, 0); // CBNZ
        add_op(8,  11'b01010100,    K_BC,  5'b00000, 2'b00, 0, 0, 0); // B.cond
        add_op(6,  11'b000101,      K_B,   5'b00000, 2'b00, 0, 0, 0); // B

        m_flags = 4'b0000;
        reset_n = 1'b1;
        instr   = 32'h0;
        status  = 4'h0;
        #2 reset_n = 1'b0;
        @(negedge clock);
        check_reset_values("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // ADD X1,X2,X3
        run_instr("ADD", 32'h8B030041, 4'b0000);
        check("ADD fs literal", 64'(cap_fs), 64'h08);
        check("ADD pc_sel literal", 64'(cap_pc_sel), 64'd0);

        // SUBS then B.EQ, taken and not taken
        run_instr("SUBS z", 32'hEB030041, 4'b0110);
        check("SUBS flags literal", 64'(cap_flags), 64'h6);
        run_instr("B.EQ t", 32'h54000040, 4'b0000);
        check("B.EQ taken literal", 64'(cap_pc_sel), 64'd1);
        run_instr("SUBS nz", 32'hEB030041, 4'b0000);
        run_instr("B.EQ nt", 32'h54000040, 4'b0110);
        check("B.EQ not-taken literal", 64'(cap_pc_sel), 64'd0);

        // Signed and unsigned conditions with N=V=1, C=Z=0
        run_instr("SUBS nv", 32'hEB030041, 4'b1001);
        run_instr("B.GE", 32'h5400004A, 4'b0000);
        run_instr("B.LT", 32'h5400004B, 4'b0000);
        run_instr("B.HI", 32'h54000048, 4'b0000);
        run_instr("B.LS", 32'h54000049, 4'b0000);
        run_instr("B.AL", 32'h5400004E, 4'b0000);

        // ANDS sets V; a non-S op must leave the flags alone
        run_instr("ANDS", 32'hEA010043, 4'b1000);
        run_instr("ORR", 32'hAA030041, 4'b0000);
        run_instr("B.VS", 32'h54000046, 4'b0000);
        run_instr("B.VC", 32'h54000047, 4'b0000);

        // Memory ops
        run_instr("LDUR", 32'hF85F8025, 4'b0000);
        check("LDUR imm literal", cap_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        run_instr("STUR", 32'hF8010047, 4'b0000);

        // Compare-and-branch and unconditional branch
        run_instr("CBNZ", 32'hB5FFFFE3, 4'b0000);
        check("CBNZ offset literal", cap_boff, 64'hFFFF_FFFF_FFFF_FFFC);
        check("CBNZ taken literal", 64'(cap_pc_sel), 64'd1);
        run_instr("CBZ nt", 32'hB4000083, 4'b0000);
        run_instr("CBZ t", 32'hB4000083, 4'b0010);
        run_instr("B fwd", 32'h14000010, 4'b0000);
        check("B offset literal", cap_boff, 64'h40);
        run_instr("B back", 32'h17FFFFFF, 4'b0000);

        // Immediate forms and shift
        run_instr("ADDI", 32'h912AF062, 4'b0000);
        run_instr("EORI", 32'hD23FFC20, 4'b0000);
        run_instr("LSL", 32'hD3601CA4, 4'b0000);
        check("LSL imm literal", cap_imm, 64'd7);

        // Asynchronous reset mid-EXECUTE with non-zero flags
        run_instr("SUBS pre", 32'hEB030041, 4'b0110);
        instr  = 32'h8B030041;
        status = 4'b0000;
        check("abort c1 state", 64'(state), 64'd0);
        @(negedge clock);
        @(negedge clock);
        check("abort c3 state", 64'(state), 64'd2);
        reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        m_flags = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
        run_instr("post-abort ADD", 32'h8B030041, 4'b0000);

        // Undecodable opcode traps and stays trapped
        instr = 32'hFFFF_FFFF;
        check("trap c1 state", 64'(state), 64'd0);
        @(negedge clock);
        check("trap c2 state", 64'(state), 64'd1);
        check("trap c2 illegal", 64'(illegal), 64'd0);
        instr = 32'h8B030041;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check($sformatf("trap t%0d state", i), 64'(state), 64'd5);
            check($sformatf("trap t%0d illegal", i), 64'(illegal), 64'd1);
            check($sformatf("trap t%0d enables", i),
                  64'({reg_write, mem_read, mem_write, mem_to_reg, pc_we, pc_sel}), 64'd0);
        end
        reset_n = 1'b0;
        #1;
        check_reset_values("trap clear");
        @(negedge clock);
        reset_n = 1'b1;
        run_instr("post-trap ADD", 32'h8B030041, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
